// File: rtl/gate_check_pkg.sv
// Shared types and truth-table constants for the gate check sequencer.
package gate_check_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [3:0] TT_NAND2 = 4'b0111;
    localparam logic [3:0] TT_AND2  = 4'b1000;
    localparam logic [3:0] TT_OR2   = 4'b1110;
    localparam logic [3:0] TT_XOR2  = 4'b0110;
    localparam logic [1:0] TT_NOT   = 2'b01;

endpackage

// File: rtl/gate_check_sequencer.sv
// Sweeps all N-bit input vectors onto a combinational DUT, holds each for SETTLE
// cycles, and scores the sampled result against the TRUTH table.
module gate_check_sequencer
    import gate_check_pkg::*;
#(
    parameter int                N      = 2,
    parameter int                SETTLE = 1,
    parameter logic [2**N-1:0]   TRUTH  = TT_NAND2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    output logic [N-1:0]   stim,
    input  logic           dut_r,
    output logic           busy,
    output logic           done,
    output logic           pass,
    output logic [N:0]     err_count,
    output logic           fail_seen,
    output logic [N-1:0]   first_fail
);

    localparam int               CNT_W    = $clog2(SETTLE) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

    state_t           state_q, state_d;
    logic [N-1:0]     stim_q, stim_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [N:0]       err_q, err_d;
    logic             fail_seen_q, fail_seen_d;
    logic [N-1:0]     first_fail_q, first_fail_d;

    logic             mismatch;

    assign mismatch = (dut_r != TRUTH[stim_q]);

    always_comb begin
        state_d      = state_q;
        stim_d       = stim_q;
        cnt_d        = cnt_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        pass_d       = pass_q;
        err_d        = err_q;
        fail_seen_d  = fail_seen_q;
        first_fail_d = first_fail_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_SETTLE;
                    stim_d       = '0;
                    cnt_d        = '0;
                    busy_d       = 1'b1;
                    err_d        = '0;
                    fail_seen_d  = 1'b0;
                    first_fail_d = '0;
                end
            end
            S_SETTLE: begin
                if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    if (mismatch) begin
                        err_d = err_q + 1'b1;
                        if (!fail_seen_q) begin
                            fail_seen_d  = 1'b1;
                            first_fail_d = stim_q;
                        end
                    end
                    // Last vector: pass must see this final sample's mismatch too.
                    if (stim_q == '1) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                    end else begin
                        stim_d = stim_q + 1'b1;
                        cnt_d  = '0;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            stim_q       <= '0;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_q        <= '0;
            fail_seen_q  <= 1'b0;
            first_fail_q <= '0;
        end else begin
            state_q      <= state_d;
            stim_q       <= stim_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_q        <= err_d;
            fail_seen_q  <= fail_seen_d;
            first_fail_q <= first_fail_d;
        end
    end

    assign stim       = stim_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign fail_seen  = fail_seen_q;
    assign first_fail = first_fail_q;

endmodule

// File: tb/tb_gate_check_sequencer.sv
// Directed bench for gate_check_sequencer: default NAND instance, a SETTLE=3
// instance and an XOR instance driven from one linear stimulus sequence.
module tb_gate_check_sequencer;
    import gate_check_pkg::*;

    logic clk;
    logic reset;

    // Default instance (NAND truth, SETTLE=1); dut_r source selected by mode.
    logic       start0;
    logic [1:0] stim0;
    logic       dut_r0;
    logic       busy0, done0, pass0, fail0;
    logic [2:0] err0;
    logic [1:0] ff0;
    int         mode;   // 0: NAND, 1: tied 1, 2: tied 0

    // SETTLE=3 instance with a correct NAND.
    logic       start3;
    logic [1:0] stim3;
    logic       dut_r3;
    logic       busy3, done3, pass3, fail3;
    logic [2:0] err3;
    logic [1:0] ff3;

    // XOR instance with a correct XOR.
    logic       startx;
    logic [1:0] stimx;
    logic       dut_rx;
    logic       busyx, donex, passx, failx;
    logic [2:0] errx;
    logic [1:0] ffx;

    int total;
    int passed;

    assign dut_r0 = (mode == 0) ? ~(stim0[1] & stim0[0]) : (mode == 1);
    assign dut_r3 = ~(stim3[1] & stim3[0]);
    assign dut_rx = stimx[1] ^ stimx[0];

    gate_check_sequencer u_dut0 (
        .clk(clk), .reset(reset), .start(start0), .stim(stim0), .dut_r(dut_r0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .fail_seen(fail0), .first_fail(ff0)
    );

    gate_check_sequencer #(.N(2), .SETTLE(3), .TRUTH(TT_NAND2)) u_dut3 (
        .clk(clk), .reset(reset), .start(start3), .stim(stim3), .dut_r(dut_r3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
        .fail_seen(fail3), .first_fail(ff3)
    );

    gate_check_sequencer #(.N(2), .SETTLE(1), .TRUTH(TT_XOR2)) u_dutx (
        .clk(clk), .reset(reset), .start(startx), .stim(stimx), .dut_r(dut_rx),
        .busy(busyx), .done(donex), .pass(passx), .err_count(errx),
        .fail_seen(failx), .first_fail(ffx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        total  = 0;
        passed = 0;
        mode   = 0;
        reset  = 1'b1;
        start0 = 1'b0;
        start3 = 1'b0;
        startx = 1'b0;
        tick();
        tick();

        check("rst_stim", stim0, 0);
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_pass", pass0, 0);
        check("rst_err", err0, 0);
        check("rst_fail_seen", fail0, 0);
        check("rst_first_fail", ff0, 0);
        reset = 1'b0;
        tick();
        check("idle_hold_busy", busy0, 0);

        // Test 1: correct NAND, one sweep
        mode   = 0;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        check("t1_e0_busy", busy0, 1);
        check("t1_e0_stim", stim0, 0);
        tick();
        check("t1_stim1", stim0, 1);
        tick();
        check("t1_stim2", stim0, 2);
        tick();
        check("t1_stim3", stim0, 3);
        check("t1_not_done_yet", done0, 0);
        tick();
        check("t1_done", done0, 1);
        check("t1_busy_low", busy0, 0);
        check("t1_pass", pass0, 1);
        check("t1_err", err0, 0);
        check("t1_fail_seen", fail0, 0);
        tick();
        check("t1_done_drop", done0, 0);
        check("t1_stim_hold", stim0, 3);

        // Test 2: dut_r tied 1, only final vector mismatches
        mode   = 1;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        check("t2_pass_held", pass0, 1);
        repeat (3) tick();
        tick();
        check("t2_done", done0, 1);
        check("t2_err", err0, 1);
        check("t2_fail_seen", fail0, 1);
        check("t2_first_fail", ff0, 3);
        check("t2_pass", pass0, 0);
        tick();

        // Test 3: dut_r tied 0, then a clean NAND sweep
        mode   = 2;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        check("t3a_err_cleared", err0, 0);
        check("t3a_fail_cleared", fail0, 0);
        repeat (3) tick();
        tick();
        check("t3a_done", done0, 1);
        check("t3a_err", err0, 3);
        check("t3a_first_fail", ff0, 0);
        check("t3a_pass", pass0, 0);
        tick();
        mode   = 0;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        check("t3b_err_cleared", err0, 0);
        check("t3b_fail_cleared", fail0, 0);
        check("t3b_pass_held", pass0, 0);
        repeat (3) tick();
        tick();
        check("t3b_done", done0, 1);
        check("t3b_pass", pass0, 1);
        check("t3b_err", err0, 0);
        tick();

        // Test 4: SETTLE=3, extra start mid-sweep
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        check("t4_e0_stim", stim3, 0);
        check("t4_e0_busy", busy3, 1);
        for (int i = 1; i < 12; i++) begin
            start3 = (i == 5);
            tick();
            check("t4_stim", stim3, i / 3);
            check("t4_no_done", done3, 0);
        end
        start3 = 1'b0;
        tick();
        check("t4_done", done3, 1);
        check("t4_pass", pass3, 1);
        check("t4_err", err3, 0);
        tick();
        check("t4_idle_done", done3, 0);
        tick();
        check("t4_no_restart", busy3, 0);

        // Test 5: reset in the 2nd cycle of a sweep
        mode   = 2;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        tick();
        check("t5_pre_err", err0, 1);
        check("t5_pre_stim", stim0, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_rst_stim", stim0, 0);
        check("t5_rst_busy", busy0, 0);
        check("t5_rst_pass", pass0, 0);
        check("t5_rst_err", err0, 0);
        check("t5_rst_fail_seen", fail0, 0);
        check("t5_rst_first_fail", ff0, 0);
        tick();
        check("t5_idle", busy0, 0);
        mode   = 0;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        check("t5_restart_busy", busy0, 1);
        repeat (3) tick();
        tick();
        check("t5_done", done0, 1);
        check("t5_pass", pass0, 1);
        check("t5_err", err0, 0);

        // Test 6: start held high on the XOR instance
        startx = 1'b1;
        tick();
        check("t6_e0_busy", busyx, 1);
        for (int i = 1; i <= 18; i++) begin
            tick();
            check("t6_done", donex, (i % 6) == 4);
            if ((i % 6) == 4) begin
                check("t6_pass", passx, 1);
                check("t6_err_at_done", errx, 0);
            end
            if ((i % 6) == 0) begin
                check("t6_restart_busy", busyx, 1);
                check("t6_restart_err", errx, 0);
            end
        end
        startx = 1'b0;
        repeat (8) tick();
        check("t6_stopped", busyx, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
